// File: rtl/ddr_mem_model_if.sv
// rtl/ddr_mem_model_if.sv - request/response bundle between a DDR requester and ddr_mem_model
//
// Requester side (master) drives: ddr_r_en_i, ddr_w_en_i, ddr_address_i, ddr_w_data_i.
// Memory side (slave) drives: req_ready_o, ddr_w_done_o, ddr_r_data_o, ddr_r_valid_o,
// err_o, outstanding_o.
interface ddr_mem_model_if #(
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 8,
  parameter int MaxOutstanding = 4
);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  logic                 ddr_r_en_i;
  logic                 ddr_w_en_i;
  logic [AddrWidth-1:0] ddr_address_i;
  logic [DataWidth-1:0] ddr_w_data_i;
  logic                 req_ready_o;
  logic                 ddr_w_done_o;
  logic [DataWidth-1:0] ddr_r_data_o;
  logic                 ddr_r_valid_o;
  logic                 err_o;
  logic [CntWidth-1:0]  outstanding_o;

  modport master (
    output ddr_r_en_i, ddr_w_en_i, ddr_address_i, ddr_w_data_i,
    input  req_ready_o, ddr_w_done_o, ddr_r_data_o, ddr_r_valid_o, err_o, outstanding_o
  );

  modport slave (
    input  ddr_r_en_i, ddr_w_en_i, ddr_address_i, ddr_w_data_i,
    output req_ready_o, ddr_w_done_o, ddr_r_data_o, ddr_r_valid_o, err_o, outstanding_o
  );
endinterface

// File: rtl/ddr_mem_model.sv
// rtl/ddr_mem_model.sv - pipelined DDR memory responder with backpressure and in-order responses
//
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_i  - asynchronous active-high reset (memory contents are kept)
//   ddr    - slave side of ddr_mem_model_if: request inputs, ready/done/read data/valid,
//            error pulse and in-flight count
module ddr_mem_model #(
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 8,
  parameter int Depth          = 256,
  parameter int Latency        = 3,
  parameter int MaxOutstanding = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  ddr_mem_model_if.slave ddr
);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic                 valid;
    logic                 is_write;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
  } req_t;

  logic                 both_en;
  logic                 accept;
  logic                 addr_ok;
  logic                 commit_write;
  logic [CntWidth-1:0]  outstanding_q;
  logic [IdxWidth-1:0]  idx;
  req_t                 in_req;
  req_t                 head;
  logic [DataWidth-1:0] mem [Depth];

  assign ddr.req_ready_o   = (outstanding_q < CntWidth'(MaxOutstanding));
  assign ddr.outstanding_o = outstanding_q;

  assign both_en = ddr.ddr_r_en_i & ddr.ddr_w_en_i;
  assign accept  = (ddr.ddr_r_en_i ^ ddr.ddr_w_en_i) & ddr.req_ready_o;

  always_comb begin
    in_req          = '0;
    in_req.valid    = accept;
    in_req.is_write = ddr.ddr_w_en_i;
    in_req.addr     = ddr.ddr_address_i;
    in_req.wdata    = ddr.ddr_w_data_i;
  end

  // The response registers act as the final latency stage, so only Latency-1
  // stages of storage sit between acceptance and the response edge.
  if (Latency == 1) begin : g_direct
    assign head = in_req;
  end else begin : g_pipe
    req_t stage_q [Latency-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < Latency - 1; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= in_req;
        for (int i = 1; i < Latency - 1; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign head = stage_q[Latency-2];
  end

  assign addr_ok = ({1'b0, head.addr} < (AddrWidth + 1)'(Depth));
  assign idx     = head.addr[IdxWidth-1:0];
  // With Latency=1 the head comes straight from the inputs, so block commits
  // while reset is held.
  assign commit_write = head.valid & head.is_write & addr_ok & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (commit_write) mem[idx] <= head.wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ddr.ddr_w_done_o  <= 1'b0;
      ddr.ddr_r_valid_o <= 1'b0;
      ddr.ddr_r_data_o  <= '0;
      ddr.err_o         <= 1'b0;
      outstanding_q     <= '0;
    end else begin
      ddr.ddr_w_done_o  <= head.valid & head.is_write;
      ddr.ddr_r_valid_o <= head.valid & ~head.is_write;
      // Memory is read before this edge's commit; earlier writes have already
      // landed on previous edges because responses leave in acceptance order.
      ddr.ddr_r_data_o  <= (head.valid & ~head.is_write & addr_ok) ? mem[idx] : '0;
      ddr.err_o         <= both_en | (head.valid & ~addr_ok);
      if (accept && !head.valid) begin
        outstanding_q <= outstanding_q + CntWidth'(1);
      end else if (!accept && head.valid) begin
        outstanding_q <= outstanding_q - CntWidth'(1);
      end
    end
  end
endmodule

// File: tb/tb_ddr_mem_model.sv
// tb/tb_ddr_mem_model.sv - randomized self-checking bench for ddr_mem_model against a queue-based model
module tb_ddr_mem_model;
  localparam int NI = 2;

  typedef struct {
    int          kind;  // 0 idle, 1 read, 2 write, 3 read+write together
    int          addr;
    logic [31:0] data;
  } stim_t;

  typedef struct {
    int          due;
    bit          wr;
    int          addr;
    logic [31:0] data;
  } pend_t;

  logic clk;
  logic rst;

  logic        r_en   [NI];
  logic        w_en   [NI];
  logic [7:0]  addr_d [NI];
  logic [31:0] wdat_d [NI];

  logic        o_ready [NI];
  logic        o_wd    [NI];
  logic        o_rv    [NI];
  logic        o_err   [NI];
  logic [31:0] o_rd    [NI];
  logic [3:0]  o_out   [NI];

  stim_t       sq [NI][$];
  pend_t       pq [NI][$];
  stim_t       cur [NI];
  bit          holding [NI];
  bit          perr [NI];
  logic [31:0] mem_m [int];
  int          n;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ddr_mem_model_if #(.DataWidth(32), .AddrWidth(8), .MaxOutstanding(4)) if_a ();
  ddr_mem_model_if #(.DataWidth(32), .AddrWidth(8), .MaxOutstanding(2)) if_b ();

  ddr_mem_model #(.DataWidth(32), .AddrWidth(8), .Depth(256), .Latency(3), .MaxOutstanding(4))
    u_dut_a (.clk_i(clk), .rst_i(rst), .ddr(if_a));
  ddr_mem_model #(.DataWidth(32), .AddrWidth(8), .Depth(16), .Latency(3), .MaxOutstanding(2))
    u_dut_b (.clk_i(clk), .rst_i(rst), .ddr(if_b));

  assign if_a.ddr_r_en_i    = r_en[0];
  assign if_a.ddr_w_en_i    = w_en[0];
  assign if_a.ddr_address_i = addr_d[0];
  assign if_a.ddr_w_data_i  = wdat_d[0];
  assign if_b.ddr_r_en_i    = r_en[1];
  assign if_b.ddr_w_en_i    = w_en[1];
  assign if_b.ddr_address_i = addr_d[1];
  assign if_b.ddr_w_data_i  = wdat_d[1];

  assign o_ready[0] = if_a.req_ready_o;
  assign o_wd[0]    = if_a.ddr_w_done_o;
  assign o_rv[0]    = if_a.ddr_r_valid_o;
  assign o_err[0]   = if_a.err_o;
  assign o_rd[0]    = if_a.ddr_r_data_o;
  assign o_out[0]   = 4'(if_a.outstanding_o);
  assign o_ready[1] = if_b.req_ready_o;
  assign o_wd[1]    = if_b.ddr_w_done_o;
  assign o_rv[1]    = if_b.ddr_r_valid_o;
  assign o_err[1]   = if_b.err_o;
  assign o_rd[1]    = if_b.ddr_r_data_o;
  assign o_out[1]   = 4'(if_b.outstanding_o);

  function automatic int lat_of(input int i);
    return (i == 0) ? 3 : 3;
  endfunction

  function automatic int maxo_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int dep_of(input int i);
    return (i == 0) ? 256 : 16;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic stim_t rand_stim(input int i);
    stim_t s;
    int    r;
    r      = int'($urandom_range(0, 9));
    s.kind = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
    s.addr = (i == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 23));
    s.data = $urandom;
    return s;
  endfunction

  task automatic push(input int i, input int kind, input int a, input logic [31:0] d);
    stim_t s;
    s.kind = kind;
    s.addr = a;
    s.data = d;
    sq[i].push_back(s);
  endtask

  task automatic push_both(input int kind, input int a, input logic [31:0] d);
    push(0, kind, a, d);
    push(1, kind, a, d);
  endtask

  // Called on a falling edge: checks what the last rising edge produced, then
  // drives the next request and predicts whether the coming edge accepts it.
  task automatic step(input int i, input bit rnd);
    pend_t       p;
    int          key;
    bit          exp_wd;
    bit          exp_rv;
    bit          exp_err;
    bit          chk_rd;
    bit          exp_ready;
    logic [31:0] exp_rd;
    exp_wd  = 1'b0;
    exp_rv  = 1'b0;
    exp_err = perr[i];
    exp_rd  = '0;
    chk_rd  = 1'b1;
    perr[i] = 1'b0;
    if (pq[i].size() > 0 && pq[i][0].due == n) begin
      p   = pq[i].pop_front();
      key = i * 1024 + p.addr;
      if (p.addr >= dep_of(i)) exp_err = 1'b1;
      if (p.wr) begin
        exp_wd = 1'b1;
        if (p.addr < dep_of(i)) mem_m[key] = p.data;
      end else begin
        exp_rv = 1'b1;
        if (p.addr >= dep_of(i)) exp_rd = '0;
        else if (mem_m.exists(key)) exp_rd = mem_m[key];
        else chk_rd = 1'b0;
      end
    end
    exp_ready = (pq[i].size() < maxo_of(i));
    check_eq($sformatf("i%0d req_ready", i), 32'(o_ready[i]), 32'(exp_ready));
    check_eq($sformatf("i%0d outstanding", i), 32'(o_out[i]), 32'(pq[i].size()));
    check_eq($sformatf("i%0d w_done", i), 32'(o_wd[i]), 32'(exp_wd));
    check_eq($sformatf("i%0d r_valid", i), 32'(o_rv[i]), 32'(exp_rv));
    check_eq($sformatf("i%0d err", i), 32'(o_err[i]), 32'(exp_err));
    if (chk_rd) check_eq($sformatf("i%0d r_data", i), o_rd[i], exp_rd);

    if (!holding[i]) begin
      if (sq[i].size() > 0) cur[i] = sq[i].pop_front();
      else if (rnd) cur[i] = rand_stim(i);
      else cur[i] = '{0, 0, 32'h0};
    end
    r_en[i]    = (cur[i].kind == 1 || cur[i].kind == 3);
    w_en[i]    = (cur[i].kind == 2 || cur[i].kind == 3);
    addr_d[i]  = 8'(cur[i].addr);
    wdat_d[i]  = cur[i].data;
    holding[i] = 1'b0;
    if (cur[i].kind == 3) begin
      perr[i] = 1'b1;
    end else if (cur[i].kind == 1 || cur[i].kind == 2) begin
      if (exp_ready) pq[i].push_back('{n + lat_of(i), cur[i].kind == 2, cur[i].addr, cur[i].data});
      else holding[i] = 1'b1;
    end
  endtask

  task automatic run(input int ncyc, input bit rnd);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NI; i++) step(i, rnd);
    end
  endtask

  task automatic check_idle_outputs(input string when);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s i%0d req_ready", when, i), 32'(o_ready[i]), 32'd1);
      check_eq($sformatf("%s i%0d outstanding", when, i), 32'(o_out[i]), 32'd0);
      check_eq($sformatf("%s i%0d w_done", when, i), 32'(o_wd[i]), 32'd0);
      check_eq($sformatf("%s i%0d r_valid", when, i), 32'(o_rv[i]), 32'd0);
      check_eq($sformatf("%s i%0d err", when, i), 32'(o_err[i]), 32'd0);
      check_eq($sformatf("%s i%0d r_data", when, i), o_rd[i], 32'd0);
    end
  endtask

  // Entered just after a falling edge; asserts reset immediately, discards
  // everything in flight in the model and releases on a later falling edge.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      r_en[i]    = 1'b0;
      w_en[i]    = 1'b0;
      holding[i] = 1'b0;
      perr[i]    = 1'b0;
      pq[i].delete();
    end
    #1;
    check_idle_outputs("rst_assert");
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_idle_outputs("rst_hold");
    end
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n        = 0;
    rst      = 1'b1;
    for (int i = 0; i < NI; i++) begin
      r_en[i]    = 1'b0;
      w_en[i]    = 1'b0;
      addr_d[i]  = '0;
      wdat_d[i]  = '0;
      holding[i] = 1'b0;
      perr[i]    = 1'b0;
      cur[i]     = '{0, 0, 32'h0};
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    push_both(2, 5, 32'hDEADBEEF);
    push_both(1, 5, 32'h0);
    run(10, 1'b0);

    for (int a = 1; a <= 3; a++) push_both(2, a, 32'h1111 * a);
    for (int a = 1; a <= 3; a++) push_both(1, a, 32'h0);
    run(14, 1'b0);

    push_both(2, 7, 32'h11);
    push_both(2, 7, 32'h22);
    push_both(1, 7, 32'h0);
    run(10, 1'b0);

    push_both(3, 7, 32'h99);
    push_both(1, 7, 32'h0);
    run(10, 1'b0);

    push(1, 1, 20, 32'h0);
    push(1, 2, 20, 32'h77);
    push(1, 1, 20, 32'h0);
    push(1, 1, 15, 32'h0);
    push(1, 2, 15, 32'h5A);
    push(1, 1, 15, 32'h0);
    run(16, 1'b0);

    run(1500, 1'b1);
    run(12, 1'b0);

    push_both(2, 3, 32'hA5);
    run(8, 1'b0);
    push_both(1, 3, 32'h0);
    run(2, 1'b0);
    do_reset(2);
    push_both(1, 3, 32'h0);
    run(8, 1'b0);

    run(1500, 1'b1);
    do_reset(1);
    run(1500, 1'b1);
    run(12, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
